vx_fence_tracker: RTL and testbench
===================================

# vx_fence_tracker

Per-warp outstanding-store tracker and memory-fence sequencer between the issue stage and the LSU. It generalises the single global "no pending stores" indication into per-warp store counters with configurable depth and store-ack channel count. It sequences fence/atomic requests per warp: new stores from a fencing warp are blocked until that warp drains, then one done pulse is issued per cycle, arbitrated round-robin. A global mode keeps the legacy all-warps-drained ordering.

## Interface
- NUM_WARPS, 8: warps tracked; NW_W = max(1, $clog2(NUM_WARPS))
- CNT_WIDTH, 5: per-warp counter width; max count CMAX = 2^CNT_WIDTH-1
- NUM_ACKS, 2: store-ack channels per cycle
- GLOBAL_FENCE, 0: 0 = fence waits on own warp only; 1 = fence waits on all warps
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- st_valid  in  1  store dispatched to LSU
- st_wid  in  NW_W  warp of dispatched store
- st_ready  out  1  store may be dispatched (combinational from registers and st_wid)
- ack_valid  in  NUM_ACKS  per-channel store commit
- ack_wid  in  NUM_ACKS*NW_W  warp per ack channel
- fence_valid  in  1  fence/atomic request from issue
- fence_wid  in  NW_W  requesting warp
- fence_ready  out  1  fence accepted (combinational)
- done_valid  out  1  registered one-cycle completion pulse
- done_wid  out  NW_W  warp whose fence completed
- pending_mask  out  NUM_WARPS  bit w = count[w] != 0
- no_pending_stores  out  1  all counters zero
- err_underflow  out  1  sticky: ack arrived for a zero counter

## Operation
- State: count[w] (CNT_WIDTH), fpend[w] (1 bit), rr_ptr (NW_W), done regs, err flag.
- st_ready = !fpend[st_wid] && count[st_wid] != CMAX. A store is counted only when st_valid && st_ready. st_valid with st_ready low is ignored; no state changes.
- fence_ready = !fpend[fence_wid]. On fence_valid && fence_ready, fpend[fence_wid] is set.
- Counter update each edge: count[w] += inc_w - dec_w.
  - inc_w is 0 or 1.
  - dec_w = popcount of ack channels with ack_wid == w; multiple acks to one warp in one cycle are all counted.
  - Width is CNT_WIDTH+$clog2(NUM_ACKS+1)+1 internally, clamped to [0, CMAX].
- Underflow: if dec_w > count[w] + inc_w, count[w] ends at 0 and err_underflow is set. err_underflow is cleared only by reset.
- Eligibility:
  - GLOBAL_FENCE=0: elig[w] = fpend[w] && count[w]==0.
  - GLOBAL_FENCE=1: elig[w] = fpend[w] && all counts == 0.
  - Both use registered values.
- Arbitration: among elig, the first warp at or after rr_ptr (wrapping) is selected. At the next edge:
  - done_valid=1, done_wid=selected, fpend[selected] cleared.
  - rr_ptr = selected+1, mod NUM_WARPS.
  - With no eligible warp, done_valid=0.
- A fence accepted in the same cycle its warp's fpend clears is impossible, because fence_ready is low while fpend is set.
- no_pending_stores and pending_mask are decoded from the count registers, so they have no combinational path from inputs.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): all counts 0, fpend 0, rr_ptr 0, done_valid 0, done_wid 0, err_underflow 0, pending_mask 0, no_pending_stores 1. st_ready and fence_ready are 1 after reset.
- Reset asserted mid-operation discards all counts and pending fences, and emits no done pulse.
- Store/ack effect appears in count, pending_mask and no_pending_stores at the next edge (1-cycle latency).
- Fence accepted in cycle T with count 0 and no store in T:
  - cycle T+1: fpend=1, eligible
  - cycle T+2: done_valid=1
  - minimum fence latency is 2 cycles.
- Fence with N outstanding stores, last ack in cycle A: count 0 at A+1, done_valid at A+2 (if it wins arbitration).
- A store and an ack to the same warp in the same cycle give a net count change of 0.
- At count CMAX, st_ready drops for that warp. An ack in the same cycle does not reopen st_ready until the next cycle.
- Simultaneous fence acceptance and last ack for that warp: count 0 and fpend 1 both at T+1; done at T+2.
- done_valid is never asserted on two consecutive cycles for the same warp without a new fence being accepted in between.

## Test plan
- Reset: drive reset=0 mid-traffic with count[3]=4 and fpend[3]=1 -> all outputs take their reset values immediately; after release, no done pulse for warp 3.
- Drain:
  - 3 stores warp 2 in cycles 0–2; fence warp 2 in cycle 3; st_valid warp 2 in cycle 4 -> st_ready=0.
  - acks in cycles 6, 7, 8 -> count[2]=0 at cycle 9, done_valid=1, done_wid=2 at cycle 10.
- Multi-ack: count[1]=2; both ack channels target warp 1 plus a store to warp 1 in the same cycle -> count[1]=1 next cycle, err_underflow=0.
- Saturation/underflow (CNT_WIDTH=2):
  - 3 stores to warp 0, then st_valid -> st_ready=0, count stays 3.
  - 4 acks to warp 0 -> count 0, err_underflow=1 and stays set.
- Round-robin: fences to warps 0, 5 and 7, all with count 0, accepted in the same window -> done pulses in order 0, 5, 7 on consecutive cycles. With a new fence on 0 and rr_ptr=1, warp 5 wins over 0.
- Global mode (GLOBAL_FENCE=1): fence warp 4 with count[4]=0 and count[6]=1 -> no done. The ack to warp 6 in cycle A gives done_wid=4 at A+2, and no_pending_stores=1 from A+1.

Source files
------------

// File: rtl/vx_fence_tracker.sv
// vx_fence_tracker
// Per-warp outstanding-store counters plus a fence/atomic sequencer that sits
// between issue and the LSU. A fencing warp has its new stores blocked until
// its counter drains (or until every counter drains in GLOBAL_FENCE mode).
// Completions are then reported one per cycle, chosen round-robin.

module vx_fence_tracker #(
    parameter int  NUM_WARPS    = 8,
    parameter int  CNT_WIDTH    = 5,
    parameter int  NUM_ACKS     = 2,
    parameter int  GLOBAL_FENCE = 0,
    localparam int NW_W         = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [NW_W-1:0]          st_wid,
    output logic                     st_ready,
    input  logic [NUM_ACKS-1:0]      ack_valid,
    input  logic [NUM_ACKS*NW_W-1:0] ack_wid,
    input  logic                     fence_valid,
    input  logic [NW_W-1:0]          fence_wid,
    output logic                     fence_ready,
    output logic                     done_valid,
    output logic [NW_W-1:0]          done_wid,
    output logic [NUM_WARPS-1:0]     pending_mask,
    output logic                     no_pending_stores,
    output logic                     err_underflow
);

    localparam logic [CNT_WIDTH-1:0] CMAX  = '1;
    // Enough bits to hold the number of acks that can hit one warp per cycle.
    localparam int                   DEC_W = $clog2(NUM_ACKS + 1);
    // Count plus increment minus decrement, with one spare bit so the
    // underflow compare never wraps.
    localparam int                   SUM_W = CNT_WIDTH + DEC_W + 1;

    logic [CNT_WIDTH-1:0] count     [NUM_WARPS];
    logic [CNT_WIDTH-1:0] count_nxt [NUM_WARPS];
    logic [NUM_WARPS-1:0] fpend;
    logic [NUM_WARPS-1:0] fpend_nxt;
    logic [NUM_WARPS-1:0] elig;
    logic [NW_W-1:0]      rr_ptr;
    logic [NW_W-1:0]      ptr_nxt;
    logic [NW_W-1:0]      sel_wid;
    logic                 sel_valid;
    logic                 underflow;
    logic                 st_fire;
    logic                 fence_fire;

    // Handshake decode: look up the addressed warp's registered state.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the loop leaves it unassigned (which infers a latch).
        st_ready    = 1'b0;
        fence_ready = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (st_wid == NW_W'(w)) begin
                st_ready = !fpend[w] && (count[w] != CMAX);
            end
            if (fence_wid == NW_W'(w)) begin
                fence_ready = !fpend[w];
            end
        end
    end

    assign st_fire    = st_valid && st_ready;
    assign fence_fire = fence_valid && fence_ready;

    // Status flags come straight from the counter registers.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            pending_mask[w] = (count[w] != '0);
        end
        no_pending_stores = ~|pending_mask;
    end

    // Next counter value: +1 for an accepted store, -n for n acks this cycle,
    // clamped to [0, CMAX]; going below zero flags an underflow.
    always_comb begin
        logic [DEC_W-1:0] dec;
        logic [SUM_W-1:0] sum;
        dec       = '0;
        sum       = '0;
        underflow = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            dec = '0;
            for (int a = 0; a < NUM_ACKS; a++) begin
                if (ack_valid[a] && (ack_wid[a*NW_W +: NW_W] == NW_W'(w))) begin
                    dec = dec + DEC_W'(1);
                end
            end
            sum = SUM_W'(count[w]) + SUM_W'(st_fire && (st_wid == NW_W'(w)));
            if (SUM_W'(dec) > sum) begin
                count_nxt[w] = '0;
                underflow    = 1'b1;
            end else if ((sum - SUM_W'(dec)) > SUM_W'(CMAX)) begin
                count_nxt[w] = CMAX;
            end else begin
                count_nxt[w] = CNT_WIDTH'(sum - SUM_W'(dec));
            end
        end
    end

    // A pending fence is eligible once the stores it orders against drained.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (GLOBAL_FENCE != 0) begin
                elig[w] = fpend[w] && no_pending_stores;
            end else begin
                elig[w] = fpend[w] && !pending_mask[w];
            end
        end
    end

    // Round-robin pick: first eligible warp at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        sel_valid = 1'b0;
        sel_wid   = '0;
        ptr_nxt   = rr_ptr;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_WARPS;
            if (!sel_valid && elig[idx]) begin
                sel_valid = 1'b1;
                sel_wid   = NW_W'(idx);
                ptr_nxt   = NW_W'((idx + 1) % NUM_WARPS);
            end
        end
    end

    // Fence-pending flags: set on acceptance, cleared when the warp completes.
    // The same warp cannot do both in one cycle because fence_ready is low
    // while its flag is set.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            fpend_nxt[w] = fpend[w];
            if (fence_fire && (fence_wid == NW_W'(w))) begin
                fpend_nxt[w] = 1'b1;
            end
            if (sel_valid && (sel_wid == NW_W'(w))) begin
                fpend_nxt[w] = 1'b0;
            end
        end
    end

    // State registers; reset drops all counts and pending fences.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the counter array is architectural state that must read
            // zero after reset, so every entry is cleared here like a flop.
            for (int w = 0; w < NUM_WARPS; w++) begin
                count[w] <= '0;
            end
            fpend         <= '0;
            rr_ptr        <= '0;
            done_valid    <= 1'b0;
            done_wid      <= '0;
            err_underflow <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the pre-edge values regardless of order.
            for (int w = 0; w < NUM_WARPS; w++) begin
                count[w] <= count_nxt[w];
            end
            fpend         <= fpend_nxt;
            rr_ptr        <= ptr_nxt;
            done_valid    <= sel_valid;
            done_wid      <= sel_valid ? sel_wid : done_wid;
            err_underflow <= err_underflow | underflow;
        end
    end

endmodule

// File: tb/tb_vx_fence_tracker.sv
// Self-checking bench for vx_fence_tracker. Three instances share stimulus:
// default parameters, CNT_WIDTH=2 for saturation/underflow, GLOBAL_FENCE=1
// for legacy ordering. Expected done pulses go into a scoreboard queue when
// the releasing stimulus is driven and are popped by a negedge monitor.

module tb_vx_fence_tracker;

    logic       clk;
    logic       reset;
    logic       st_valid;
    logic [2:0] st_wid;
    logic [1:0] ack_valid;
    logic [5:0] ack_wid;
    logic       fence_valid;
    logic [2:0] fence_wid;

    logic       m_st_ready, m_fence_ready, m_done_valid, m_nps, m_err;
    logic [2:0] m_done_wid;
    logic [7:0] m_pending;
    logic       s_st_ready, s_fence_ready, s_done_valid, s_nps, s_err;
    logic [2:0] s_done_wid;
    logic [7:0] s_pending;
    logic       g_st_ready, g_fence_ready, g_done_valid, g_nps, g_err;
    logic [2:0] g_done_wid;
    logic [7:0] g_pending;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         mon_sel = -1;
    logic [2:0] sb_q[$];
    logic       mon_dv;
    logic [2:0] mon_dw;
    logic [2:0] mon_exp;

    vx_fence_tracker u_dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_wid(st_wid), .st_ready(m_st_ready),
        .ack_valid(ack_valid), .ack_wid(ack_wid),
        .fence_valid(fence_valid), .fence_wid(fence_wid), .fence_ready(m_fence_ready),
        .done_valid(m_done_valid), .done_wid(m_done_wid),
        .pending_mask(m_pending), .no_pending_stores(m_nps), .err_underflow(m_err)
    );

    vx_fence_tracker #(.CNT_WIDTH(2)) u_sat (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_wid(st_wid), .st_ready(s_st_ready),
        .ack_valid(ack_valid), .ack_wid(ack_wid),
        .fence_valid(fence_valid), .fence_wid(fence_wid), .fence_ready(s_fence_ready),
        .done_valid(s_done_valid), .done_wid(s_done_wid),
        .pending_mask(s_pending), .no_pending_stores(s_nps), .err_underflow(s_err)
    );

    vx_fence_tracker #(.GLOBAL_FENCE(1)) u_glb (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_wid(st_wid), .st_ready(g_st_ready),
        .ack_valid(ack_valid), .ack_wid(ack_wid),
        .fence_valid(fence_valid), .fence_wid(fence_wid), .fence_ready(g_fence_ready),
        .done_valid(g_done_valid), .done_wid(g_done_wid),
        .pending_mask(g_pending), .no_pending_stores(g_nps), .err_underflow(g_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        st_valid    = 1'b0;
        st_wid      = 3'd0;
        ack_valid   = 2'b00;
        ack_wid     = 6'd0;
        fence_valid = 1'b0;
        fence_wid   = 3'd0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    task automatic store(input logic [2:0] w);
        idle();
        st_valid = 1'b1;
        st_wid   = w;
        cyc();
    endtask

    task automatic fence(input logic [2:0] w);
        idle();
        fence_valid = 1'b1;
        fence_wid   = w;
        cyc();
    endtask

    // Scoreboard monitor: every done pulse of the selected instance must match
    // the oldest expected warp; a pulse with nothing expected is an error.
    always @(negedge clk) begin
        if (reset && mon_sel >= 0) begin
            case (mon_sel)
                0:       begin mon_dv = m_done_valid; mon_dw = m_done_wid; end
                1:       begin mon_dv = s_done_valid; mon_dw = s_done_wid; end
                default: begin mon_dv = g_done_valid; mon_dw = g_done_wid; end
            endcase
            if (mon_dv) begin
                if (sb_q.size() == 0) begin
                    check("done_unexpected", {31'd0, mon_dv}, 32'd0);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("sb_done_wid", {29'd0, mon_dw}, {29'd0, mon_exp});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b0;
        #12;
        check("rst_st_ready",    m_st_ready,    1);
        check("rst_fence_ready", m_fence_ready, 1);
        check("rst_done_valid",  m_done_valid,  0);
        check("rst_done_wid",    m_done_wid,    0);
        check("rst_pending",     m_pending,     0);
        check("rst_nps",         m_nps,         1);
        check("rst_err",         m_err,         0);
        reset = 1'b1;
        cyc();

        // ---- drain: 3 stores on warp 2, fence, blocked store, 3 acks ----
        mon_sel = 0;
        for (int k = 0; k < 3; k++) store(3'd2);
        idle();
        fence_valid = 1'b1;
        fence_wid   = 3'd2;
        #1 check("drain_fence_ready", m_fence_ready, 1);
        sb_q.push_back(3'd2);
        cyc();
        idle();
        st_valid = 1'b1;
        st_wid   = 3'd2;
        #1 check("drain_st_blocked", m_st_ready, 0);
        cyc();
        idle();
        check("drain_cnt_held", m_pending[2], 1);
        cyc();
        for (int k = 0; k < 3; k++) begin
            idle();
            ack_valid = 2'b01;
            ack_wid   = {3'd0, 3'd2};
            cyc();
        end
        check("drain_cnt_zero",  m_pending[2], 0);
        check("drain_no_early",  m_done_valid, 0);
        idle();
        cyc();
        check("drain_done",      m_done_valid, 1);
        check("drain_done_wid",  m_done_wid,   2);
        cyc();
        check("drain_done_once", m_done_valid, 0);

        // ---- multi-ack: count[1]=2, two acks + one store -> 1 ----
        store(3'd1);
        store(3'd1);
        idle();
        st_valid  = 1'b1;
        st_wid    = 3'd1;
        ack_valid = 2'b11;
        ack_wid   = {3'd1, 3'd1};
        cyc();
        check("mack_cnt_one", m_pending[1], 1);
        check("mack_no_err",  m_err,        0);
        idle();
        ack_valid = 2'b01;
        ack_wid   = {3'd0, 3'd1};
        cyc();
        check("mack_cnt_zero", m_pending[1], 0);
        check("mack_no_err2",  m_err,        0);
        check("mack_nps",      m_nps,        1);
        check("sb_empty_a", sb_q.size(), 0);

        // ---- async reset mid-operation: count[3]=4, fpend[3]=1 ----
        do_reset();
        for (int k = 0; k < 4; k++) store(3'd3);
        fence(3'd3);
        idle();
        fence_wid = 3'd3;
        st_valid  = 1'b1;
        st_wid    = 3'd3;
        #1;
        check("mid_fence_blocked", m_fence_ready, 0);
        check("mid_cnt",           m_pending[3],  1);
        #2 reset = 1'b0;
        #1;
        check("arst_pending",     m_pending,     0);
        check("arst_nps",         m_nps,         1);
        check("arst_done",        m_done_valid,  0);
        check("arst_st_ready",    m_st_ready,    1);
        check("arst_fence_ready", m_fence_ready, 1);
        idle();
        #3 reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("arst_no_done", m_done_valid, 0);
        end
        check("arst_cnt3", m_pending[3], 0);

        // ---- round-robin: 0,5,7 released together, then 5 beats 0 ----
        do_reset();
        store(3'd7);
        store(3'd5);
        fence(3'd7);
        fence(3'd5);
        fence(3'd0);
        idle();
        ack_valid = 2'b11;
        ack_wid   = {3'd5, 3'd7};
        sb_q.push_back(3'd0);
        sb_q.push_back(3'd5);
        sb_q.push_back(3'd7);
        cyc();
        idle();
        check("rr_v0", m_done_valid, 1);
        check("rr_w0", m_done_wid,   0);
        cyc();
        check("rr_v1", m_done_valid, 1);
        check("rr_w1", m_done_wid,   5);
        cyc();
        check("rr_v2", m_done_valid, 1);
        check("rr_w2", m_done_wid,   7);
        sb_q.push_back(3'd0);
        fence(3'd0);
        check("rr_gap", m_done_valid, 0);
        idle();
        cyc();
        check("rr_solo_wid", m_done_wid, 0);
        store(3'd5);
        store(3'd0);
        fence(3'd0);
        fence(3'd5);
        idle();
        ack_valid = 2'b11;
        ack_wid   = {3'd0, 3'd5};
        sb_q.push_back(3'd5);
        sb_q.push_back(3'd0);
        cyc();
        idle();
        cyc();
        check("rr_ptr_v", m_done_valid, 1);
        check("rr_ptr_w", m_done_wid,   5);
        cyc();
        check("rr_wrap_w", m_done_wid,  0);
        cyc();
        check("sb_empty_b", sb_q.size(), 0);

        // ---- global mode: fence 4 waits for warp 6's store ----
        mon_sel = 2;
        do_reset();
        store(3'd6);
        idle();
        fence_valid = 1'b1;
        fence_wid   = 3'd4;
        #1 check("glb_fence_ready", g_fence_ready, 1);
        sb_q.push_back(3'd4);
        cyc();
        for (int k = 0; k < 3; k++) begin
            check("glb_no_done", g_done_valid, 0);
            idle();
            cyc();
        end
        check("glb_nps_before", g_nps, 0);
        idle();
        ack_valid = 2'b10;
        ack_wid   = {3'd6, 3'd0};
        cyc();
        idle();
        check("glb_nps_a1",  g_nps,        1);
        check("glb_done_a1", g_done_valid, 0);
        cyc();
        check("glb_done_a2", g_done_valid, 1);
        check("glb_wid_a2",  g_done_wid,   4);
        cyc();
        check("sb_empty_c", sb_q.size(), 0);

        // ---- saturation and underflow with CNT_WIDTH=2 ----
        mon_sel = -1;
        do_reset();
        for (int k = 0; k < 3; k++) store(3'd0);
        idle();
        st_valid = 1'b1;
        st_wid   = 3'd0;
        #1 check("sat_st_ready", s_st_ready, 0);
        cyc();
        idle();
        ack_valid = 2'b11;
        ack_wid   = {3'd0, 3'd0};
        cyc();
        check("sat_cnt_one", s_pending[0], 1);
        check("sat_no_err",  s_err,        0);
        cyc();
        idle();
        check("uf_cnt_zero", s_pending[0], 0);
        check("uf_err_set",  s_err,        1);
        cyc();
        store(3'd0);
        check("uf_err_sticky", s_err, 1);
        check("uf_recount",    s_pending[0], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
